// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants and types for the ECC_ENC_DEC APB job master.
package ecc_pkg;

  // ECC register offsets relative to the register base.
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_DATA_IN  = 8'h04;
  localparam logic [7:0] OFF_CW_WIDTH = 8'h08;
  localparam logic [7:0] OFF_NOISE    = 8'h0C;

  // CTRL encodings (3 is reserved and passed through untouched).
  localparam logic [1:0] CTRL_ENCODE = 2'd0;
  localparam logic [1:0] CTRL_DECODE = 2'd1;
  localparam logic [1:0] CTRL_FULL   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } ecc_state_e;

  // Write list order; the numeric value doubles as the pending-mask bit for
  // the three optional registers.
  typedef enum logic [1:0] {
    WR_DATA_IN  = 2'd0,
    WR_CW_WIDTH = 2'd1,
    WR_NOISE    = 2'd2,
    WR_CTRL     = 2'd3
  } wr_idx_e;

  function automatic logic [7:0] wr_offset(input wr_idx_e idx);
    logic [7:0] off;
    off = OFF_CTRL;
    case (idx)
      WR_DATA_IN:  off = OFF_DATA_IN;
      WR_CW_WIDTH: off = OFF_CW_WIDTH;
      WR_NOISE:    off = OFF_NOISE;
      default:     off = OFF_CTRL;
    endcase
    return off;
  endfunction

  // Lowest pending optional write, or CTRL once none are left.
  function automatic wr_idx_e next_write(input logic [2:0] pend);
    wr_idx_e idx;
    if (pend[0])      idx = WR_DATA_IN;
    else if (pend[1]) idx = WR_CW_WIDTH;
    else if (pend[2]) idx = WR_NOISE;
    else              idx = WR_CTRL;
    return idx;
  endfunction

endpackage

// File: rtl/ecc_apb_wr.sv
// ecc_apb_wr: one two-phase APB write channel (SETUP then ACCESS, no PREADY).
// A start pulse during the ACCESS cycle chains the next transfer with no gap.
module ecc_apb_wr
  import ecc_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AMBA_ADDR_WIDTH-1:0] addr,
  input  logic [AMBA_WORD-1:0]       data,
  output logic                       psel,
  output logic                       penable,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  output logic                       done
);

  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;

  // Phase sequencing: start -> SETUP, SETUP -> ACCESS, ACCESS -> idle or chained SETUP.
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (start) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = addr;
      pwdata_d  = data;
    end else if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (psel_q && penable_q) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  // Bus flops; async reset drops PSEL/PENABLE immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign done    = psel_q & penable_q;

endmodule

// File: rtl/ecc_job_master.sv
// ecc_job_master: takes one ECC job, programs the ECC register file over APB
// (skipping registers whose shadow already holds the value), waits for
// operation_done or a timeout, and hands back the result.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | job_ready=1, waiting for a job
// ST_SETUP  | APB setup phase of the current write
// ST_ACCESS | APB access phase; shadow updates, chain next write or wait
// ST_WAIT   | waiting for operation_done, timeout counter running
// ST_RESP   | result held until res_ready
module ecc_job_master
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int BASE_ADDR       = 0,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_ctrl,
  input  logic [AMBA_WORD-1:0]       job_data,
  input  logic [1:0]                 job_width,
  input  logic [AMBA_WORD-1:0]       job_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_errors,
  output logic                       res_timeout,
  output logic                       busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AMBA_ADDR_WIDTH-1:0] BASE = AMBA_ADDR_WIDTH'(BASE_ADDR);

  ecc_state_e             state_q, state_d;
  wr_idx_e                wr_idx_q, wr_idx_d;
  logic [2:0]             pend_q, pend_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic [AMBA_WORD-1:0]   data_q, data_d;
  logic [1:0]             width_q, width_d;
  logic [AMBA_WORD-1:0]   noise_q, noise_d;
  logic [AMBA_WORD-1:0]   sh_data_q, sh_data_d;
  logic [1:0]             sh_width_q, sh_width_d;
  logic [AMBA_WORD-1:0]   sh_noise_q, sh_noise_d;
  logic [2:0]             sh_vld_q, sh_vld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   job_ready_q, job_ready_d;
  logic                   busy_q, busy_d;
  logic                   res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0]  res_data_q, res_data_d;
  logic [1:0]             res_errors_q, res_errors_d;
  logic                   res_timeout_q, res_timeout_d;

  logic                       wr_start;
  logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
  logic [AMBA_WORD-1:0]       wr_data;
  logic                       wr_done;
  logic                       wr_psel, wr_penable;
  logic [2:0]                 pend_new, pend_nxt;
  wr_idx_e                    idx_new;

  function automatic logic [AMBA_WORD-1:0] wr_value(
    input wr_idx_e              idx,
    input logic [1:0]           c,
    input logic [AMBA_WORD-1:0] d,
    input logic [1:0]           w,
    input logic [AMBA_WORD-1:0] n
  );
    logic [AMBA_WORD-1:0] v;
    v = AMBA_WORD'(c);
    case (idx)
      WR_DATA_IN:  v = d;
      WR_CW_WIDTH: v = AMBA_WORD'(w);
      WR_NOISE:    v = n;
      default:     v = AMBA_WORD'(c);
    endcase
    return v;
  endfunction

  // Next-state, write sequencing, shadow update, timeout and result capture.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    pend_d        = pend_q;
    ctrl_d        = ctrl_q;
    data_d        = data_q;
    width_d       = width_q;
    noise_d       = noise_q;
    sh_data_d     = sh_data_q;
    sh_width_d    = sh_width_q;
    sh_noise_d    = sh_noise_q;
    sh_vld_d      = sh_vld_q;
    cnt_d         = cnt_q;
    job_ready_d   = job_ready_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_errors_d  = res_errors_q;
    res_timeout_d = res_timeout_q;
    wr_start      = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    pend_nxt      = pend_q;
    idx_new       = WR_CTRL;

    pend_new = {!(sh_vld_q[2] && (sh_noise_q == job_noise)),
                !(sh_vld_q[1] && (sh_width_q == job_width)),
                !(sh_vld_q[0] && (sh_data_q  == job_data))};

    case (state_q)
      ST_IDLE: begin
        if (job_valid && job_ready_q) begin
          ctrl_d      = job_ctrl;
          data_d      = job_data;
          width_d     = job_width;
          noise_d     = job_noise;
          pend_d      = pend_new;
          idx_new     = next_write(pend_new);
          wr_idx_d    = idx_new;
          wr_start    = 1'b1;
          wr_addr     = BASE + AMBA_ADDR_WIDTH'(wr_offset(idx_new));
          wr_data     = wr_value(idx_new, job_ctrl, job_data, job_width, job_noise);
          job_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (wr_done) begin
          case (wr_idx_q)
            WR_DATA_IN: begin
              sh_data_d   = data_q;
              sh_vld_d[0] = 1'b1;
              pend_nxt[0] = 1'b0;
            end
            WR_CW_WIDTH: begin
              sh_width_d  = width_q;
              sh_vld_d[1] = 1'b1;
              pend_nxt[1] = 1'b0;
            end
            WR_NOISE: begin
              sh_noise_d  = noise_q;
              sh_vld_d[2] = 1'b1;
              pend_nxt[2] = 1'b0;
            end
            default: ;
          endcase
          pend_d = pend_nxt;
          if (wr_idx_q == WR_CTRL) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            idx_new  = next_write(pend_nxt);
            wr_idx_d = idx_new;
            wr_start = 1'b1;
            wr_addr  = BASE + AMBA_ADDR_WIDTH'(wr_offset(idx_new));
            wr_data  = wr_value(idx_new, ctrl_q, data_q, width_q, noise_q);
            state_d  = ST_SETUP;
          end
        end
      end
      ST_WAIT: begin
        if (operation_done) begin
          res_data_d    = data_out;
          res_errors_d  = num_of_errors;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d    = '0;
          res_errors_d  = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          job_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        job_ready_d = 1'b1;
        res_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_idx_q      <= WR_CTRL;
      pend_q        <= '0;
      ctrl_q        <= '0;
      data_q        <= '0;
      width_q       <= '0;
      noise_q       <= '0;
      sh_data_q     <= '0;
      sh_width_q    <= '0;
      sh_noise_q    <= '0;
      sh_vld_q      <= '0;
      cnt_q         <= '0;
      job_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_errors_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      pend_q        <= pend_d;
      ctrl_q        <= ctrl_d;
      data_q        <= data_d;
      width_q       <= width_d;
      noise_q       <= noise_d;
      sh_data_q     <= sh_data_d;
      sh_width_q    <= sh_width_d;
      sh_noise_q    <= sh_noise_d;
      sh_vld_q      <= sh_vld_d;
      cnt_q         <= cnt_d;
      job_ready_q   <= job_ready_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_errors_q  <= res_errors_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  ecc_apb_wr #(
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
    .AMBA_WORD       (AMBA_WORD)
  ) u_apb_wr (
    .clk     (clk),
    .rst     (rst),
    .start   (wr_start),
    .addr    (wr_addr),
    .data    (wr_data),
    .psel    (wr_psel),
    .penable (wr_penable),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .done    (wr_done)
  );

  assign PSEL        = wr_psel;
  assign PENABLE     = wr_penable;
  assign PWRITE      = wr_psel;
  assign job_ready   = job_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_errors  = res_errors_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_ecc_job_master.sv
// tb_ecc_job_master: directed jobs with hand-computed APB write sequences,
// done/timeout handling, result backpressure and mid-transfer reset.
module tb_ecc_job_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_ctrl;
  logic [31:0] job_data;
  logic [1:0]  job_width;
  logic [31:0] job_noise;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_errors;
  logic        res_timeout;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] exp_addr [4];
  logic [31:0] exp_data [4];

  always #5 clk = ~clk;

  ecc_job_master #(
    .DATA_WIDTH      (32),
    .AMBA_ADDR_WIDTH (20),
    .AMBA_WORD       (32),
    .BASE_ADDR       (0),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_ctrl       (job_ctrl),
    .job_data       (job_data),
    .job_width      (job_width),
    .job_noise      (job_noise),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .operation_done (operation_done),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_errors     (res_errors),
    .res_timeout    (res_timeout),
    .busy           (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one job in the current (IDLE) cycle and check n writes from exp_*.
  // Returns in the first WAIT cycle.
  task automatic do_job(input logic [1:0] c, input logic [31:0] d, input logic [1:0] w,
                        input logic [31:0] n, input int nwr);
    check_val("job_ready_idle", job_ready, 1);
    job_ctrl  = c;
    job_data  = d;
    job_width = w;
    job_noise = n;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    check_val("job_ready_taken", job_ready, 0);
    for (int k = 0; k < nwr; k++) begin
      check_val($sformatf("setup%0d_psel", k), {PSEL, PENABLE, PWRITE}, 3'b101);
      check_val($sformatf("setup%0d_paddr", k), PADDR, exp_addr[k]);
      check_val($sformatf("setup%0d_pwdata", k), PWDATA, exp_data[k]);
      tick();
      check_val($sformatf("access%0d_psel", k), {PSEL, PENABLE, PWRITE}, 3'b111);
      check_val($sformatf("access%0d_paddr", k), PADDR, exp_addr[k]);
      check_val($sformatf("access%0d_pwdata", k), PWDATA, exp_data[k]);
      tick();
    end
    check_val("wait_psel", {PSEL, PENABLE}, 2'b00);
    check_val("wait_busy", busy, 1);
    check_val("wait_no_res", res_valid, 0);
  endtask

  initial begin
    rst            = 1'b1;
    job_valid      = 1'b0;
    job_ctrl       = '0;
    job_data       = '0;
    job_width      = '0;
    job_noise      = '0;
    operation_done = 1'b0;
    data_out       = '0;
    num_of_errors  = '0;
    res_ready      = 1'b0;
    #2 rst = 1'b0;
    #20;
    check_val("rst_job_ready", job_ready, 1);
    check_val("rst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
    check_val("rst_paddr", PADDR, 0);
    check_val("rst_res", {res_valid, res_timeout, busy}, 3'b000);
    check_val("rst_res_data", res_data, 0);
    #10 rst = 1'b1;
    tick();

    // Job A: all four writes, done at cycle 12 -> res_valid at 13.
    exp_addr[0] = 20'h04; exp_data[0] = 32'hA5;
    exp_addr[1] = 20'h08; exp_data[1] = 32'h0;
    exp_addr[2] = 20'h0C; exp_data[2] = 32'h0;
    exp_addr[3] = 20'h00; exp_data[3] = 32'h0;
    do_job(2'd0, 32'hA5, 2'd0, 32'h0, 4);          // now cycle 9
    tick(); tick(); tick();                         // cycle 12
    check_val("a_no_res_before_done", res_valid, 0);
    operation_done = 1'b1;
    data_out       = 32'h1234;
    num_of_errors  = 2'd1;
    tick();                                         // cycle 13
    operation_done = 1'b0;
    check_val("a_res_valid", res_valid, 1);
    check_val("a_res_data", res_data, 32'h1234);
    check_val("a_res_errors", res_errors, 1);
    check_val("a_res_timeout", res_timeout, 0);
    check_val("a_job_ready_resp", job_ready, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("a_back_idle", {res_valid, busy, job_ready}, 3'b001);

    // Job B: identical fields, ctrl=1 -> CTRL write only; done in first WAIT cycle.
    exp_addr[0] = 20'h00; exp_data[0] = 32'h1;
    do_job(2'd1, 32'hA5, 2'd0, 32'h0, 1);          // WAIT at cycle 3
    operation_done = 1'b1;
    data_out       = 32'hBEEF;
    num_of_errors  = 2'd2;
    tick();
    operation_done = 1'b0;
    data_out       = 32'h0;
    check_val("b_res_valid", res_valid, 1);
    check_val("b_res_data", res_data, 32'hBEEF);
    check_val("b_res_errors", res_errors, 2);
    // Backpressure: res_ready low for 5 cycles while another job is offered.
    job_valid = 1'b1;
    job_data  = 32'h77;
    job_noise = 32'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("b_hold%0d_valid", i), {res_valid, job_ready, busy}, 3'b101);
      check_val($sformatf("b_hold%0d_data", i), res_data, 32'hBEEF);
      check_val($sformatf("b_hold%0d_apb", i), PSEL, 0);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("b_back_idle", {res_valid, busy, job_ready}, 3'b001);

    // Job C: only noise changes -> NOISE then CTRL; no done -> timeout after 8.
    exp_addr[0] = 20'h0C; exp_data[0] = 32'h1;
    exp_addr[1] = 20'h00; exp_data[1] = 32'h1;
    do_job(2'd1, 32'hA5, 2'd0, 32'h1, 2);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_val($sformatf("c_wait%0d_no_res", i), res_valid, 0);
    end
    tick();
    check_val("c_to_valid", res_valid, 1);
    check_val("c_to_flag", res_timeout, 1);
    check_val("c_to_data", res_data, 0);
    check_val("c_to_errors", res_errors, 0);
    operation_done = 1'b1;
    data_out       = 32'h5555;
    num_of_errors  = 2'd3;
    tick();
    operation_done = 1'b0;
    check_val("c_resp_done_ignored", {res_valid, res_timeout}, 2'b11);
    check_val("c_resp_data_kept", res_data, 0);
    res_ready = 1'b1;
    tick();
    res_ready      = 1'b0;
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    check_val("c_idle_done_ignored", {res_valid, busy, job_ready}, 3'b001);
    check_val("c_idle_apb", PSEL, 0);

    // Job D: reset during ACCESS of the NOISE write.
    check_val("d_job_ready", job_ready, 1);
    job_ctrl  = 2'd0;
    job_data  = 32'hA5;
    job_width = 2'd0;
    job_noise = 32'h2;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    check_val("d_setup_noise", {PSEL, PENABLE, PADDR}, {2'b10, 20'h0C});
    tick();
    check_val("d_access_noise", {PSEL, PENABLE, PADDR}, {2'b11, 20'h0C});
    #2 rst = 1'b0;
    #1;
    check_val("d_rst_apb", {PSEL, PENABLE}, 2'b00);
    check_val("d_rst_state", {busy, job_ready, res_valid}, 3'b010);
    #3 rst = 1'b1;
    tick();

    // Job E: shadows invalidated by reset -> all four writes again.
    exp_addr[0] = 20'h04; exp_data[0] = 32'hA5;
    exp_addr[1] = 20'h08; exp_data[1] = 32'h0;
    exp_addr[2] = 20'h0C; exp_data[2] = 32'h2;
    exp_addr[3] = 20'h00; exp_data[3] = 32'h0;
    do_job(2'd0, 32'hA5, 2'd0, 32'h2, 4);
    tick();
    operation_done = 1'b1;
    data_out       = 32'hCAFE_0001;
    num_of_errors  = 2'd0;
    res_ready      = 1'b1;
    tick();
    operation_done = 1'b0;
    check_val("e_res", {res_valid, res_timeout}, 2'b10);
    check_val("e_res_data", res_data, 32'hCAFE_0001);
    tick();
    res_ready = 1'b0;
    check_val("e_back_idle", {res_valid, busy, job_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_job_master.md
# ecc_job_master

Upstream APB master for `ECC_ENC_DEC`. Accepts one encode/decode/full-channel job at a time over a valid/ready handshake and programs the ECC register file with APB write transfers. It then waits for `operation_done` and returns `data_out`/`num_of_errors` over a second valid/ready handshake. It is the sole APB master on the ECC slave; a timeout guards against a hung slave.

## Interface
- DATA_WIDTH, 32, ECC data/codeword width
- AMBA_ADDR_WIDTH, 20, PADDR width
- AMBA_WORD, 32, PWDATA width
- BASE_ADDR, 0, ECC register base; offsets CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C
- TIMEOUT_CYCLES, 1023, max WAIT cycles before abort (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  block can accept a job
- job_ctrl  in  2  0 encode, 1 decode, 2 full channel (3 reserved, passed through)
- job_data  in  AMBA_WORD  DATA_IN value
- job_width  in  2  CODEWORD_WIDTH value
- job_noise  in  AMBA_WORD  NOISE value
- PADDR  out  AMBA_ADDR_WIDTH  APB address
- PWDATA  out  AMBA_WORD  APB write data
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- operation_done  in  1  ECC completion pulse
- data_out  in  DATA_WIDTH  ECC result
- num_of_errors  in  2  ECC error count
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_data  out  DATA_WIDTH  captured data_out
- res_errors  out  2  captured num_of_errors
- res_timeout  out  1  job aborted by timeout
- busy  out  1  high in any state but IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, WAIT, RESP.
- IDLE: job_ready=1. On job_valid&&job_ready, latch all job fields and build a write list in fixed order DATA_IN, CODEWORD_WIDTH, NOISE, CTRL.
- Shadow skip: each of DATA_IN/CODEWORD_WIDTH/NOISE has a shadow register plus valid bit. A write is dropped when the shadow is valid and equals the new value. CTRL is always written; the CTRL write starts the ECC operation.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=BASE_ADDR+offset, PWDATA=value. Fields narrower than AMBA_WORD are zero-extended.
- ACCESS: PSEL=1, PENABLE=1, PADDR/PWDATA unchanged. The slave has no PREADY, so every transfer is exactly 2 cycles. The shadow updates at ACCESS end. Next state is SETUP of the next write (back-to-back, no idle gap) or WAIT after CTRL.
- WAIT: PSEL=0. The counter counts from 0. When operation_done=1, capture data_out/num_of_errors, clear res_timeout, go to RESP. When the counter reaches TIMEOUT_CYCLES-1 with no done, set res_data=0, res_errors=0, res_timeout=1, and go to RESP.
- RESP: res_valid=1 and res_* stable until res_valid&&res_ready, then go to IDLE. job_ready stays 0 in RESP.
- operation_done outside WAIT is ignored.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0 except job_ready=1; shadows invalidated; counter 0. Reset mid-transfer drops PSEL/PENABLE in the same instant.
- Accept at cycle 0: first SETUP at cycle 1.
- Four writes: CTRL ACCESS at cycle 8, WAIT from cycle 9.
- All three optional writes skipped: CTRL SETUP at 1, ACCESS at 2, WAIT from 3.
- Done sampled in WAIT at cycle N: res_valid=1 from N+1.
- Done in the first WAIT cycle is honoured.
- Timeout with TIMEOUT_CYCLES=T: res_valid asserts T cycles after WAIT entry.
- res_ready already high when res_valid rises: one RESP cycle, then IDLE, job_ready=1 next cycle.

## Structure
- Package `ecc_pkg`: register offset constants, ctrl encoding constants, FSM state enum, write-index enum.
- Sub-module `ecc_apb_wr`: a single 2-phase APB write channel (start, addr, data → PSEL/PENABLE/PADDR/PWDATA, done). The top FSM sequences it and owns the shadows, timeout, and result handshake.

## Test plan
- Reset, then job ctrl=0 data=0x0000_00A5 width=0 noise=0 → 4 writes (0x04,0x08,0x0C,0x00) over cycles 1–8; done at cycle 12 with data_out=0x1234 → res_valid at 13, res_data=0x1234, res_timeout=0.
- Repeat the identical job with ctrl=1 → only the CTRL write (PWDATA=1); WAIT entered at cycle 3.
- Second job changes only noise to 0x1 → writes NOISE then CTRL only.
- TIMEOUT_CYCLES=8, done never asserted → res_valid 8 cycles after WAIT entry; res_timeout=1, res_data=0; then a done pulse in RESP/IDLE is ignored.
- res_ready held low 5 cycles → res_* stable, job_valid ignored (job_ready=0); release → IDLE.
- Assert rst during ACCESS of the NOISE write → PSEL/PENABLE=0 immediately; the next job rewrites all three registers.
